// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer request scheduler: FSM encoding,
// frame layout and watchdog sizing.
package timer_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_DONE = 3'd2,
    ACK       = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam logic [3:0] SYNC_PATTERN    = 4'b1101;
  localparam int         FRAME_LEN       = 8;
  localparam int         BIT_CNT_W       = $clog2(FRAME_LEN);
  localparam int         DEFAULT_TIMEOUT = 17000;
  localparam int         WD_W            = 15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found when searching upward from ptr, wrapping N-1 to 0.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_request_scheduler.sv
// Shares one serial-programmed timer among N_REQ requesters: arbitrates, shifts
// out a sync+delay frame, waits for timer_done under a watchdog, then acks.
module timer_request_scheduler
  import timer_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] req_delay,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done_vec,
  output logic               err,
  output logic               busy,
  output logic               timer_data,
  output logic               timer_ack,
  input  logic               timer_counting,
  input  logic               timer_done,
  output state_t             fsm_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: a requester raises req (level) and holds it until its done_vec
  // pulse; grant is one-hot for the whole SEND..ACK span and drops in GAP.
  state_t                 state;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          next_ptr;
  logic [FRAME_LEN-1:0]   frame;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [WD_W-1:0]        wdog;
  logic [N_REQ-1:0]       arb_gnt;
  logic [3:0]             win_delay;
  logic                   unused_counting;

  assign unused_counting = timer_counting;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_gnt)
  );

  always_comb begin
    win_delay = 4'd0;
    next_ptr  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_delay = req_delay[4*i +: 4];
        next_ptr  = (i == N_REQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      done_vec  <= '0;
      err       <= 1'b0;
      timer_ack <= 1'b0;
      frame     <= '0;
      bit_cnt   <= '0;
      wdog      <= '0;
      rr_ptr    <= '0;
    end else begin
      done_vec  <= '0;
      err       <= 1'b0;
      timer_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state   <= SEND;
            grant   <= arb_gnt;
            frame   <= {SYNC_PATTERN, win_delay};
            bit_cnt <= '0;
            rr_ptr  <= next_ptr;
          end
        end
        SEND: begin
          frame   <= {frame[FRAME_LEN-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_CNT_W'(FRAME_LEN - 1)) begin
            state <= WAIT_DONE;
            wdog  <= '0;
          end
        end
        WAIT_DONE: begin
          // timer_done wins over a coincident watchdog expiry.
          if (timer_done) begin
            state     <= ACK;
            timer_ack <= 1'b1;
            done_vec  <= grant;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            state     <= ACK;
            timer_ack <= 1'b1;
            done_vec  <= grant;
            err       <= 1'b1;
          end else if (wdog != '1) begin
            wdog <= wdog + 1'b1;
          end
        end
        ACK: begin
          state <= GAP;
          grant <= '0;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign timer_data = (state == SEND) & frame[FRAME_LEN-1];
  assign busy       = (state != IDLE);
  assign fsm_state  = state;

endmodule

// File: tb/tb_timer_request_scheduler.sv
// Directed bench for timer_request_scheduler: table of full transactions plus
// hand-written reset, request-drop and round-robin corner sequences.
module tb_timer_request_scheduler;
  import timer_sched_pkg::*;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 17000;

  logic               clk;
  logic               reset;
  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] req_delay;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done_vec;
  logic               err;
  logic               busy;
  logic               timer_data;
  logic               timer_ack;
  logic               timer_counting;
  logic               timer_done;
  state_t             fsm_state;

  int tests_run;
  int tests_failed;
  int done_after;
  int wait_cnt;

  timer_request_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_delay      (req_delay),
    .grant          (grant),
    .done_vec       (done_vec),
    .err            (err),
    .busy           (busy),
    .timer_data     (timer_data),
    .timer_ack      (timer_ack),
    .timer_counting (timer_counting),
    .timer_done     (timer_done),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hung expected finish");
    $fatal(1, "simulation time limit");
  end

  // Stub timer: raises timer_done on the done_after-th WAIT_DONE cycle (-1 = never).
  initial begin
    timer_done     = 1'b0;
    timer_counting = 1'b0;
    wait_cnt       = 0;
    forever begin
      @(negedge clk);
      timer_done = 1'b0;
      if (fsm_state == WAIT_DONE) begin
        wait_cnt       = wait_cnt + 1;
        timer_counting = 1'b1;
        if (done_after >= 0 && wait_cnt == done_after) timer_done = 1'b1;
      end else begin
        wait_cnt       = 0;
        timer_counting = 1'b0;
      end
    end
  end

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: one full transaction, returning at the GAP-cycle negedge
  task automatic run_txn(input logic [3:0] r, input logic [15:0] d, input int da,
                         input logic [3:0] eg, input logic [7:0] ef,
                         input logic ee, input int ew);
    int n;
    int w;
    logic [7:0] f;
    f          = ef;
    req        = r;
    req_delay  = d;
    done_after = da;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == '0 && n < 20);
    if (grant == '0) begin
      check("grant_wait", 32'(n), 32'(0));
      return;
    end
    check("grant", 32'(grant), 32'(eg));
    for (int i = 0; i < FRAME_LEN; i++) begin
      check("frame_bit", 32'(timer_data), 32'(f[7-i]));
      check("send_no_done", 32'({done_vec, err, timer_ack}), 32'(0));
      if (i < FRAME_LEN - 1) @(negedge clk);
    end
    w = 0;
    @(negedge clk);
    while (!timer_ack && w < TIMEOUT + 100) begin
      w++;
      @(negedge clk);
    end
    check("wait_cycles", 32'(w), 32'(ew));
    check("ack", 32'(timer_ack), 32'(1));
    check("done_vec", 32'(done_vec), 32'(eg));
    check("err", 32'(err), 32'(ee));
    @(negedge clk);
    check("gap_grant", 32'(grant), 32'(0));
    check("gap_quiet", 32'({done_vec, err, timer_ack, timer_data}), 32'(0));
    check("gap_busy", 32'(busy), 32'(1));
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] delay;
    int          done_after;
    logic [3:0]  gnt;
    logic [7:0]  frame;
    logic        err;
    int          wait_cycles;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n;
    tests_run    = 0;
    tests_failed = 0;
    done_after   = -1;
    reset        = 1'b1;
    req          = '0;
    req_delay    = '0;

    // Pointer starts at 0 after reset; entries run back to back so it carries.
    vecs[0]  = '{4'b0001, 16'h0001, 2000,    4'b0001, 8'hD1, 1'b0, 2000};
    vecs[1]  = '{4'b1111, 16'h4321, 3,       4'b0010, 8'hD2, 1'b0, 3};
    vecs[2]  = '{4'b1111, 16'h4321, 3,       4'b0100, 8'hD3, 1'b0, 3};
    vecs[3]  = '{4'b1111, 16'h4321, 3,       4'b1000, 8'hD4, 1'b0, 3};
    vecs[4]  = '{4'b1111, 16'h4321, 3,       4'b0001, 8'hD1, 1'b0, 3};
    vecs[5]  = '{4'b1111, 16'h4321, 3,       4'b0010, 8'hD2, 1'b0, 3};
    vecs[6]  = '{4'b1001, 16'hF00A, 4,       4'b1000, 8'hDF, 1'b0, 4};
    vecs[7]  = '{4'b1001, 16'hF00A, 4,       4'b0001, 8'hDA, 1'b0, 4};
    vecs[8]  = '{4'b0100, 16'h0500, 4,       4'b0100, 8'hD5, 1'b0, 4};
    vecs[9]  = '{4'b0011, 16'h00E0, 4,       4'b0001, 8'hD0, 1'b0, 4};
    vecs[10] = '{4'b1000, 16'h7000, -1,      4'b1000, 8'hD7, 1'b1, TIMEOUT};
    vecs[11] = '{4'b0010, 16'h0090, TIMEOUT, 4'b0010, 8'hD9, 1'b0, TIMEOUT};

    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({grant, done_vec, err, busy, timer_data, timer_ack}), 32'(0));
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_req", 32'({busy, grant}), 32'(0));

    for (int v = 0; v < 12; v++)
      run_txn(vecs[v].req, vecs[v].delay, vecs[v].done_after, vecs[v].gnt,
              vecs[v].frame, vecs[v].err, vecs[v].wait_cycles);
    req = '0;
    @(negedge clk);
    check("busy_falls", 32'(busy), 32'(0));
    check("idle_after_gap", 32'(fsm_state), 32'(IDLE));

    // req0 dropped mid-wait still completes; next grant goes to requester 2
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    req        = 4'b0101;
    req_delay  = 16'h0207;
    done_after = 5;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fsm_state != WAIT_DONE && n < 30);
    check("drop_grant", 32'(grant), 32'(4'b0001));
    req = 4'b0100;
    n = 0;
    while (!timer_ack && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drop_done", 32'(done_vec), 32'(4'b0001));
    check("drop_err", 32'(err), 32'(0));
    @(negedge clk);
    run_txn(4'b0100, 16'h0207, 3, 4'b0100, 8'hD2, 1'b0, 3);
    req = '0;
    @(negedge clk);

    // reset on the 4th SEND cycle aborts silently, then a fresh frame restarts
    req        = 4'b0001;
    req_delay  = 16'h0006;
    done_after = 3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == '0 && n < 20);
    check("abort_first_bit", 32'(timer_data), 32'(1));
    repeat (3) @(negedge clk);
    check("abort_4th_bit", 32'(timer_data), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    check("abort_grant", 32'(grant), 32'(0));
    check("abort_quiet", 32'({done_vec, err, timer_ack, timer_data, busy}), 32'(0));
    check("abort_state", 32'(fsm_state), 32'(IDLE));
    reset = 1'b0;
    run_txn(4'b0001, 16'h0006, 3, 4'b0001, 8'hD6, 1'b0, 3);
    req = '0;
    @(negedge clk);
    check("final_idle", 32'(busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
